uart_tx: RTL and testbench

//  8-bit UART transmitter, LSB first, idle-high line; counterpart of the UART receive path.

---
 rtl/uart_tx.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter (LSB first, idle-high line) fed by a small FIFO.
// Latency: push at edge k into an empty FIFO while idle -> pop at k+1 -> tx low from k+2.
// Backpressure: tx_ready drops while the FIFO is full; a push offered while full is dropped.
//
// Ports:
//   clk, rst_n            system clock (posedge), asynchronous active-low reset
//   tx_data, tx_valid     byte offered by the producer
//   tx_ready              FIFO not full (from the registered entry count)
//   tx                    registered serial line
//   tx_busy               high for every line cycle of a frame, across back-to-back frames
//   fifo_count            entries currently held
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit after D7.
module uart_tx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W      = ($clog2(BAUD_TICKS) > 16) ? $clog2(BAUD_TICKS) : 16;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int FCNT_W     = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_TICKS - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         data_q, data_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [FCNT_W-1:0]  count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic baud_end;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign push     = tx_valid && !full;
  assign baud_end = (baud_q == BAUD_LAST);

  // Frame sequencing
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          // 3-bit index wraps to 0 after D7, ready to count stop bits.
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next start bit when data is waiting.
            if (!empty) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      data_d = mem_q[rd_q];
    end
  end

  // FIFO storage and occupancy
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = tx_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Line and busy are registered from the current state, so both trail the FSM by one cycle
  // and cover exactly the frame as seen on the pin.
  always_comb begin
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^data_q;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign tx_ready   = !full;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int CF    = 1_000_000;
  localparam int BR    = 100_000;
  localparam int BT    = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB1 = 10 + PAR;
  localparam int FL1 = FB1 * BT;
  localparam int FB2 = 11 + PAR;
  localparam int FL2 = FB2 * BT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_ready2;
  logic       tx, tx2;
  logic       tx_busy, tx_busy2;
  logic [2:0] fifo_count, fifo_count2;

  always #5 clk = ~clk;

  uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count));

  uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .tx(tx2), .tx_busy(tx_busy2), .fifo_count(fifo_count2));

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Reference UART frame: start, D0..D7, optional even parity, then stop bits.
  function automatic logic line_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR == 1 && idx == 9) return logic'($countones(d) % 2);
    return 1'b1;
  endfunction

  // Receiver model on dut's line: mid-bit sampling, framing/parity validated.
  typedef struct packed { logic [7:0] d; logic ok; } rx_t;
  rx_t        rx_q[$];
  rx_t        mon_r;
  int         mon_pos = -1;
  int         mon_slot;
  logic [7:0] mon_d;
  logic       mon_ok;
  int         busy_cyc = 0;
  int         busy_rise = 0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pos   = -1;
      busy_prev = 1'b0;
    end else begin
      if (tx_busy === 1'b1) busy_cyc++;
      if (tx_busy === 1'b1 && !busy_prev) busy_rise++;
      busy_prev = (tx_busy === 1'b1);
      if (mon_pos < 0 && tx === 1'b0) begin
        mon_pos = 0;
        mon_ok  = 1'b1;
        mon_d   = 8'h00;
      end
      if (mon_pos >= 0) begin
        if (mon_pos % BT == BT / 2) begin
          mon_slot = mon_pos / BT;
          if (mon_slot == 0) mon_ok = mon_ok & (tx === 1'b0);
          else if (mon_slot <= 8) mon_d[mon_slot-1] = tx;
          else if (PAR == 1 && mon_slot == 9) mon_ok = mon_ok & (tx === logic'($countones(mon_d) % 2));
          else mon_ok = mon_ok & (tx === 1'b1);
        end
        mon_pos++;
        if (mon_pos == FL1) begin
          mon_r.d  = mon_d;
          mon_r.ok = mon_ok;
          rx_q.push_back(mon_r);
          mon_pos = -1;
        end
      end
    end
  end

  logic wave [0:1023];

  typedef struct { logic [7:0] d; logic par; } vec_t;
  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bb [5];
    int         expc [5];
    int         hi, nb, w, errs, timeouts;
    logic       e;
    logic [7:0] b;
    logic [7:0] exp_q[$];

    tbl[0] = '{8'hA5, 1'b0}; tbl[1] = '{8'h07, 1'b1};
    tbl[2] = '{8'h03, 1'b0}; tbl[3] = '{8'h00, 1'b0};
    tbl[4] = '{8'hFF, 1'b0}; tbl[5] = '{8'h80, 1'b1};
    tbl[6] = '{8'h3C, 1'b0}; tbl[7] = '{8'h01, 1'b1};

    tx_valid = 1'b0; tx_data = 8'h00; tx_valid2 = 1'b0; tx_data2 = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_tx2", tx2, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tx", tx, 1);

    // Single frames from the table
    for (int vi = 0; vi < 8; vi++) begin
      busy_cyc = 0;
      rx_q.delete();
      @(negedge clk); tx_data = tbl[vi].d; tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk); tx_valid = 1'b0; tx_data = 8'($urandom);
      check($sformatf("v%0d_count_after_push", vi), fifo_count, 1);
      check($sformatf("v%0d_tx_k", vi), tx, 1);
      @(negedge clk);
      check($sformatf("v%0d_tx_k1", vi), tx, 1);
      check($sformatf("v%0d_busy_k1", vi), tx_busy, 0);
      check($sformatf("v%0d_count_after_pop", vi), fifo_count, 0);
      for (int m = 0; m < FL1; m++) begin
        @(negedge clk); wave[m] = tx;
      end
      for (int s = 0; s < FB1; s++) begin
        hi = 0;
        for (int c = 0; c < BT; c++) hi += int'(wave[s*BT+c] === 1'b1);
        if (s == 0) e = 1'b0;
        else if (s <= 8) e = tbl[vi].d[s-1];
        else if (PAR == 1 && s == 9) e = tbl[vi].par;
        else e = 1'b1;
        check($sformatf("v%0d_slot%0d_high_cycles", vi, s), hi, e ? BT : 0);
      end
      @(negedge clk);
      check($sformatf("v%0d_tx_after", vi), tx, 1);
      check($sformatf("v%0d_busy_after", vi), tx_busy, 0);
      check($sformatf("v%0d_busy_cycles", vi), busy_cyc, FL1);
      check($sformatf("v%0d_rx_frames", vi), rx_q.size(), 1);
      if (rx_q.size() > 0) check($sformatf("v%0d_rx_byte", vi), rx_q[0].d, tbl[vi].d);
    end

    // Burst of five, then hold tx_valid against a full FIFO
    bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'h3C; bb[3] = 8'h81; bb[4] = 8'h55;
    expc[0] = 1; expc[1] = 1; expc[2] = 2; expc[3] = 3; expc[4] = 4;
    busy_cyc = 0; busy_rise = 0; rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) check($sformatf("burst_count_%0d", i - 1), fifo_count, expc[i-1]);
      check($sformatf("burst_ready_%0d", i), tx_ready, 1);
      tx_data = bb[i]; tx_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    check("burst_count_4", fifo_count, 4);
    check("burst_full_ready", tx_ready, 0);
    tx_data = 8'hEE;
    errs = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (fifo_count !== 3'd4 || tx_ready !== 1'b0) errs++;
    end
    check("full_hold_unstable_cycles", errs, 0);
    tx_valid = 1'b0;
    repeat (5 * FL1 + 300) @(negedge clk);
    check("burst_frames", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (rx_q.size() > i) begin
        check($sformatf("burst_byte_%0d", i), rx_q[i].d, bb[i]);
        check($sformatf("burst_frame_ok_%0d", i), rx_q[i].ok, 1);
      end
    end
    check("burst_busy_cycles", busy_cyc, 5 * FL1);
    check("burst_busy_rises", busy_rise, 1);

    // Reset 35 cycles into a frame with another byte still queued
    rx_q.delete();
    @(negedge clk); tx_data = 8'h5A; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); tx_data = 8'hC3;
    @(posedge clk);
    @(negedge clk); tx_valid = 1'b0;
    repeat (36) @(negedge clk);
    check("pre_reset_count", fifo_count, 1);
    check("pre_reset_busy", tx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_ready", tx_ready, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    busy_cyc = 0;
    errs = 0;
    for (int c = 0; c < 3 * FL1; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) errs++;
    end
    check("post_reset_low_cycles", errs, 0);
    check("post_reset_busy_cycles", busy_cyc, 0);
    check("post_reset_frames", rx_q.size(), 0);

    // Two stop bits: two frames of 0x5A back-to-back on dut2
    nb = 0;
    @(negedge clk); tx_data2 = 8'h5A; tx_valid2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); tx_valid2 = 1'b0;
    check("sb2_tx_k1", tx2, 1);
    nb += int'(tx_busy2 === 1'b1);
    for (int m = 0; m < 2 * FL2; m++) begin
      @(negedge clk); wave[m] = tx2; nb += int'(tx_busy2 === 1'b1);
    end
    for (int s = 0; s < 2 * FB2; s++) begin
      hi = 0;
      for (int c = 0; c < BT; c++) hi += int'(wave[s*BT+c] === 1'b1);
      check($sformatf("sb2_slot%0d_high_cycles", s), hi, line_bit(8'h5A, s % FB2) ? BT : 0);
    end
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nb += int'(tx_busy2 === 1'b1);
      if (tx2 !== 1'b1) errs++;
    end
    check("sb2_idle_low_cycles", errs, 0);
    check("sb2_busy_cycles", nb, 2 * FL2);

    // Randomized traffic against the receiver model
    exp_q.delete(); rx_q.delete(); busy_cyc = 0; timeouts = 0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      b = 8'($urandom);
      tx_data = b; tx_valid = 1'b1;
      w = 0;
      while (tx_ready !== 1'b1 && w < 4 * FL1) begin
        @(negedge clk); w++;
      end
      if (w >= 4 * FL1) timeouts++;
      else exp_q.push_back(b);
      @(posedge clk);
      @(negedge clk); tx_valid = 1'b0; tx_data = 8'($urandom);
    end
    w = 0;
    while (rx_q.size() < exp_q.size() && w < 40 * FL1 + 2000) begin
      @(negedge clk); w++;
    end
    repeat (20) @(negedge clk);
    check("rand_accept_timeouts", timeouts, 0);
    check("rand_frames", rx_q.size(), exp_q.size());
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= rx_q.size() || rx_q[i].d !== exp_q[i] || rx_q[i].ok !== 1'b1) errs++;
    end
    check("rand_byte_errors", errs, 0);
    check("rand_busy_cycles", busy_cyc, exp_q.size() * FL1);
    check("rand_final_count", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
